// File: rtl/pwm_multi_channel_gen.sv
// pwm_multi_channel_gen: CH-channel PWM generator with one shared period counter.
// Each channel has debounced increase/decrease buttons, a saturating shadow duty,
// and an active duty that reloads only at the period boundary.
// Optional macro PWM_PHASE_STAGGER_EN offsets each channel's compare count by
// i*(PERIOD/CH) so that the channels' switching edges are spread out.
module pwm_multi_channel_gen #(
  parameter int unsigned CH        = 4,
  parameter int unsigned CW        = 8,
  parameter int unsigned PERIOD    = 10,
  parameter int unsigned STEP      = 1,
  parameter int unsigned DUTY_INIT = 5,
  parameter int unsigned DEB_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [CH-1:0]    ui_increase_duty,
  input  logic [CH-1:0]    ui_decrease_duty,
  output logic [CH-1:0]    uo_pwm_out,
  output logic             uo_period_start,
  output logic [CH*CW-1:0] uo_duty
);

  localparam int unsigned DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
  localparam logic [CW-1:0] STEP_C   = CW'(STEP);
  localparam logic [CW-1:0] INIT_C   = CW'(DUTY_INIT);
  localparam logic [CW:0]   PERIOD_W = (CW+1)'(PERIOD);
  localparam logic [CW:0]   STEP_W   = (CW+1)'(STEP);

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sample_en;
  logic [CH-1:0] inc_s1_q, inc_s1_d, inc_s2_q, inc_s2_d;
  logic [CH-1:0] dec_s1_q, dec_s1_d, dec_s2_q, dec_s2_d;
  logic [CH-1:0] inc_pulse, dec_pulse;
  logic [CW-1:0] shadow_q [CH];
  logic [CW-1:0] shadow_d [CH];
  logic [CW-1:0] active_q [CH];
  logic [CW-1:0] active_d [CH];
  logic [CW-1:0] pcnt [CH];
`ifdef PWM_PHASE_STAGGER_EN
  logic [CW:0]   pcnt_sum [CH];
`endif
  logic [CH-1:0] pwm_q, pwm_d;
  logic          ps_q, ps_d;

  // Debounce prescaler and period counter; both freeze while disabled
  always_comb begin
    sample_en = ena && (deb_cnt_q == DEB_LAST);
    deb_cnt_d = deb_cnt_q;
    cnt_d     = cnt_q;
    if (ena) begin
      deb_cnt_d = (deb_cnt_q == DEB_LAST) ? '0 : deb_cnt_q + DW'(1);
      cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Two-stage button sampling and single-pulse edge detection per press
  always_comb begin
    inc_s1_d  = sample_en ? ui_increase_duty : inc_s1_q;
    inc_s2_d  = sample_en ? inc_s1_q : inc_s2_q;
    dec_s1_d  = sample_en ? ui_decrease_duty : dec_s1_q;
    dec_s2_d  = sample_en ? dec_s1_q : dec_s2_q;
    inc_pulse = inc_s1_q & ~inc_s2_q & {CH{sample_en}};
    dec_pulse = dec_s1_q & ~dec_s2_q & {CH{sample_en}};
  end

  // Saturating shadow duty update, widened by one bit so nothing wraps
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (inc_pulse[i] && !dec_pulse[i]) begin
        shadow_d[i] = (({1'b0, shadow_q[i]} + STEP_W) > PERIOD_W) ?
                      PERIOD_C : shadow_q[i] + STEP_C;
      end else if (dec_pulse[i] && !inc_pulse[i]) begin
        shadow_d[i] = (shadow_q[i] < STEP_C) ? '0 : shadow_q[i] - STEP_C;
      end
    end
  end

  // Active duty reloads from shadow on the last count of the period
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      active_d[i] = (ena && (cnt_q == CNT_LAST)) ? shadow_q[i] : active_q[i];
    end
  end

  // Per-channel compare count (phase-shifted when staggering is built in)
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
      pcnt_sum[i] = {1'b0, cnt_q} + (CW+1)'(i * (PERIOD / CH));
      pcnt[i]     = (pcnt_sum[i] >= PERIOD_W) ? CW'(pcnt_sum[i] - PERIOD_W)
                                              : pcnt_sum[i][CW-1:0];
`else
      pcnt[i]     = cnt_q;
`endif
    end
  end

  // Registered compare outputs and period-start marker
  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      pwm_d[i] = ena && (pcnt[i] < active_q[i]);
    end
    ps_d = ena && (cnt_q == '0);
  end

  // Active duty readback packing
  always_comb begin
    uo_duty = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      uo_duty[i*CW +: CW] = active_q[i];
    end
  end

  assign uo_pwm_out      = pwm_q;
  assign uo_period_start = ps_q;

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q <= '0;
      cnt_q     <= '0;
      inc_s1_q  <= '0;
      inc_s2_q  <= '0;
      dec_s1_q  <= '0;
      dec_s2_q  <= '0;
      pwm_q     <= '0;
      ps_q      <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        shadow_q[i] <= INIT_C;
        active_q[i] <= INIT_C;
      end
    end else begin
      deb_cnt_q <= deb_cnt_d;
      cnt_q     <= cnt_d;
      inc_s1_q  <= inc_s1_d;
      inc_s2_q  <= inc_s2_d;
      dec_s1_q  <= dec_s1_d;
      dec_s2_q  <= dec_s2_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
      for (int unsigned i = 0; i < CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// Self-checking bench for pwm_multi_channel_gen: directed steps plus random
// buttons/enable, checked every cycle against an integer reference model.
module tb_pwm_multi_channel_gen;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 8;
  localparam int P  = 10;
  localparam int ST = 1;
  localparam int DI = 5;
  localparam int DD = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic [CH-1:0]    inc;
  logic [CH-1:0]    dec;
  logic [CH-1:0]    uo_pwm_out;
  logic             uo_period_start;
  logic [CH*CW-1:0] uo_duty;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state (plain integers)
  int m_deb, m_cnt, m_ps;
  int m_sh [CH];
  int m_act [CH];
  int m_pwm [CH];
  int m_ai [CH];
  int m_bi [CH];
  int m_ad [CH];
  int m_bd [CH];

  pwm_multi_channel_gen #(
    .CH(CH), .CW(CW), .PERIOD(P), .STEP(ST), .DUTY_INIT(DI), .DEB_DIV(DD)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .ui_increase_duty(inc), .ui_decrease_duty(dec),
    .uo_pwm_out(uo_pwm_out), .uo_period_start(uo_period_start),
    .uo_duty(uo_duty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int phase(input int c, input int i);
`ifdef PWM_PHASE_STAGGER_EN
    return (c + i * (P / CH)) % P;
`else
    return c + 0 * i;
`endif
  endfunction

  task automatic model_reset();
    m_deb = 0; m_cnt = 0; m_ps = 0;
    for (int i = 0; i < CH; i++) begin
      m_sh[i] = DI; m_act[i] = DI; m_pwm[i] = 0;
      m_ai[i] = 0; m_bi[i] = 0; m_ad[i] = 0; m_bd[i] = 0;
    end
  endtask

  // One clock of the specified behaviour, using pre-edge values throughout
  task automatic model_step();
    int smp, up, dn;
    if (rst) begin
      model_reset();
      return;
    end
    smp = (ena && m_deb == DD - 1) ? 1 : 0;
    for (int i = 0; i < CH; i++)
      m_pwm[i] = (ena && phase(m_cnt, i) < m_act[i]) ? 1 : 0;
    m_ps = (ena && m_cnt == 0) ? 1 : 0;
    if (ena && m_cnt == P - 1)
      for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
    for (int i = 0; i < CH; i++) begin
      up = smp && m_ai[i] && !m_bi[i];
      dn = smp && m_ad[i] && !m_bd[i];
      if (up && !dn) m_sh[i] = (m_sh[i] + ST > P) ? P : m_sh[i] + ST;
      if (dn && !up) m_sh[i] = (m_sh[i] < ST) ? 0 : m_sh[i] - ST;
      if (smp) begin
        m_bi[i] = m_ai[i]; m_ai[i] = int'(inc[i]);
        m_bd[i] = m_ad[i]; m_ad[i] = int'(dec[i]);
      end
    end
    if (ena) begin
      m_cnt = (m_cnt + 1) % P;
      m_deb = (m_deb + 1) % DD;
    end
  endtask

  task automatic check_all(input string tag);
    logic [CH-1:0]    ep;
    logic [CH*CW-1:0] ed;
    for (int i = 0; i < CH; i++) begin
      ep[i] = (m_pwm[i] != 0);
      ed[i*CW +: CW] = CW'(m_act[i]);
    end
    chk({tag, "_pwm"}, 64'(uo_pwm_out), 64'(ep));
    chk({tag, "_ps"}, 64'(uo_period_start), 64'(m_ps != 0));
    chk({tag, "_duty"}, 64'(uo_duty), 64'(ed));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic press(input logic [CH-1:0] im, input logic [CH-1:0] dm, input int n);
    inc = im; dec = dm;
    repeat (n) tick("press");
    inc = '0; dec = '0;
    repeat (n) tick("release");
  endtask

  function automatic logic [CW-1:0] dch(input int i);
    return uo_duty[i*CW +: CW];
  endfunction

  initial begin
    int highs, pss, k, found;
    logic [CH*CW-1:0] all5;
    for (int i = 0; i < CH; i++) all5[i*CW +: CW] = CW'(DI);
    rst = 1'b1; ena = 1'b0; inc = '0; dec = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset_duty", 64'(uo_duty), 64'(all5));
    chk("reset_pwm", 64'(uo_pwm_out), 64'(0));

    rst = 1'b0; ena = 1'b1;
    repeat (10) tick("idle");
    highs = 0; pss = 0;
    for (int c = 0; c < 20; c++) begin
      tick("idle");
      highs += int'(uo_pwm_out[0]);
      pss   += int'(uo_period_start);
    end
    chk("idle_high_ch0", 64'(highs), 64'(10));
    chk("idle_ps_count", 64'(pss), 64'(2));

    press(4'b0001, 4'b0000, 4);
    repeat (20) tick("after_inc0");
    chk("inc0_duty", 64'(dch(0)), 64'(6));
    chk("inc0_ch1", 64'(dch(1)), 64'(5));

    for (int n = 0; n < 7; n++) press(4'b0010, 4'b0000, 4);
    repeat (20) tick("after_sat_hi");
    chk("sat_hi_duty", 64'(dch(1)), 64'(10));
    highs = 0;
    for (int c = 0; c < 10; c++) begin tick("sat_hi"); highs += int'(uo_pwm_out[1]); end
    chk("sat_hi_const", 64'(highs), 64'(10));

    for (int n = 0; n < 12; n++) press(4'b0000, 4'b0100, 4);
    repeat (20) tick("after_sat_lo");
    chk("sat_lo_duty", 64'(dch(2)), 64'(0));
    highs = 0;
    for (int c = 0; c < 10; c++) begin tick("sat_lo"); highs += int'(uo_pwm_out[2]); end
    chk("sat_lo_const", 64'(highs), 64'(0));

    press(4'b1000, 4'b1000, 4);
    repeat (20) tick("after_both");
    chk("both_duty", 64'(dch(3)), 64'(5));

    found = 0;
    for (int c = 0; c < 2 * P && found == 0; c++) begin
      if (m_cnt == 3) found = 1; else tick("sync3");
    end
    chk("sync_cnt3", 64'(found), 64'(1));
    ena = 1'b0; inc = 4'b0001;
    tick("ena_off");
    chk("ena_off_pwm", 64'(uo_pwm_out), 64'(0));
    chk("ena_off_ps", 64'(uo_period_start), 64'(0));
    repeat (10) tick("ena_off");
    inc = '0;
    repeat (9) tick("ena_off");
    ena = 1'b1;
    k = 0; found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick("resume"); k++;
      if (uo_period_start) found = 1;
    end
    chk("resume_ps_delay", 64'(k), 64'(8));
    repeat (20) tick("resume");
    chk("ena_off_ignored", 64'(dch(0)), 64'(6));

    press(4'b0001, 4'b0000, 4);
    press(4'b0001, 4'b0000, 4);
    repeat (20) tick("to8");
    chk("ch0_eight", 64'(dch(0)), 64'(8));

    found = 0;
    for (int c = 0; c < 2 * P && found == 0; c++) begin
      if (m_cnt == 2) found = 1; else tick("sync2");
    end
    chk("sync_cnt2", 64'(found), 64'(1));
    chk("pre_rst_ch0_high", 64'(uo_pwm_out[0]), 64'(1));
    #2 rst = 1'b1;
    #1 model_reset();
    chk("rst_async_pwm", 64'(uo_pwm_out), 64'(0));
    chk("rst_async_ps", 64'(uo_period_start), 64'(0));
    chk("rst_async_duty", 64'(uo_duty), 64'(all5));
    repeat (2) tick("in_rst");
    rst = 1'b0;
    tick("restart");
    chk("restart_ps", 64'(uo_period_start), 64'(1));
    repeat (20) tick("restart");
    chk("restart_duty", 64'(uo_duty), 64'(all5));

    for (int c = 0; c < 500; c++) begin
      if (c % 3 == 0) begin
        inc = CH'($urandom);
        dec = CH'($urandom);
        ena = ($urandom_range(0, 9) != 0);
      end
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
